seg_counter_mux: RTL and testbench

- Parametrised successor to the single-digit LED/seven-segment blink counter.
- Prescales the system clock into a count tick and keeps an N-digit up/down counter (decimal or hex) with carry, wrap and clear.
- Drives a time-multiplexed common seven-segment display (segments a..g plus one digit-select per digit) and a heartbeat LED.
- Sits directly behind the fabric clock macro output on the board top level.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_hex_decode.sv | 22 ++
 rtl/seg_counter_mux.sv | 173 +++++++++++++++++
 tb/tb_seg_counter_mux.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment counter: digit width, segment
// width and the active-high {g,f,e,d,c,b,a} glyph table for 0-F.
package seg_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [SEG_W-1:0]   seg_t;

    // All segments dark (active-high sense).
    localparam seg_t SEG_OFF = 7'b0000000;

    // Glyphs indexed by digit value; entry 15 is listed first.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational digit-to-segment lookup. Blanked digits, and digits outside
// the decimal range when not in hex mode, show all segments off.
module seg_hex_decode
    import seg_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_blank,
    output logic [SEG_W-1:0]   o_seg
);

    // Table lookup with dark fallback.
    always_comb begin
        // NOTE: default assignment first so every path drives o_seg and no latch is inferred.
        o_seg = SEG_OFF;
        if (!i_blank && ((HEX_MODE != 0) || (i_digit <= 4'd9))) begin
            o_seg = SEG_TABLE[i_digit];
        end
    end

endmodule

// File: rtl/seg_counter_mux.sv
// Prescaled N-digit up/down counter (decimal or hex) with wrap pulse and
// heartbeat, driving a time-multiplexed seven-segment display.
module seg_counter_mux
    import seg_pkg::*;
#(
    parameter int TICK_DIV   = 20000000,
    parameter int NUM_DIGITS = 4,
    parameter int MUX_DIV    = 50000,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          up,
    input  logic                          clr,
    output logic [SEG_W-1:0]              seg,
    output logic [NUM_DIGITS-1:0]         dig,
    output logic [DIGIT_W*NUM_DIGITS-1:0] value,
    output logic                          wrap,
    output logic                          heartbeat
);

    localparam int VAL_W   = DIGIT_W * NUM_DIGITS;
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int SCAN_W  = $clog2(MUX_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam digit_t                  DIGIT_MAX = (HEX_MODE != 0) ? 4'hF : 4'h9;
    localparam seg_t                    SEG_IDLE  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0]   DIG_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PRESC_W-1:0]     r_presc;
    logic [VAL_W-1:0]       r_value;
    logic                   r_wrap;
    logic                   r_heartbeat;
    logic [SCAN_W-1:0]      r_scan_cnt;
    logic [IDX_W-1:0]       r_scan_idx;
    logic [SEG_W-1:0]       r_seg;
    logic [NUM_DIGITS-1:0]  r_dig;

    logic                   w_presc_last;
    logic                   w_tick;
    logic [VAL_W-1:0]       w_value_next;
    logic                   w_wrap_next;
    digit_t                 w_scan_digit;
    logic                   w_scan_blank;
    logic [SEG_W-1:0]       w_seg_decoded;
    logic [NUM_DIGITS-1:0]  w_dig_onehot;

    assign w_presc_last = (r_presc == PRESC_W'(TICK_DIV - 1));
    // A clear on the same cycle swallows the tick.
    assign w_tick       = en & ~clr & w_presc_last;

    // Ripple one step up or down through the digits; carry out of the top digit is a wrap.
    always_comb begin
        logic   w_carry;
        digit_t w_d;
        w_value_next = r_value;
        w_carry      = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_d = r_value[i*DIGIT_W +: DIGIT_W];
            if (w_carry) begin
                if (up) begin
                    if (w_d == DIGIT_MAX) begin
                        w_d = '0;
                    end else begin
                        w_d     = w_d + 1'b1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (w_d == '0) begin
                        w_d = DIGIT_MAX;
                    end else begin
                        w_d     = w_d - 1'b1;
                        w_carry = 1'b0;
                    end
                end
            end
            w_value_next[i*DIGIT_W +: DIGIT_W] = w_d;
        end
        w_wrap_next = w_carry;
    end

    // Prescaler, counter, wrap pulse and heartbeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_value     <= '0;
            r_wrap      <= 1'b0;
            r_heartbeat <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_wrap <= 1'b0;
            if (clr) begin
                r_presc <= '0;
                r_value <= '0;
            end else if (en) begin
                if (w_presc_last) begin
                    r_presc <= '0;
                    r_value <= w_value_next;
                    r_wrap  <= w_wrap_next;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
            if (w_tick) begin
                r_heartbeat <= ~r_heartbeat;
            end
        end
    end

    // Free-running scan timer; advances the displayed digit every MUX_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == SCAN_W'(MUX_DIV - 1)) begin
            r_scan_cnt <= '0;
            if (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
                r_scan_idx <= '0;
            end else begin
                r_scan_idx <= r_scan_idx + 1'b1;
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Pick the scanned digit and decide whether it is a leading zero to blank.
    always_comb begin
        logic w_upper_zero;
        w_scan_digit = '0;
        w_scan_blank = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero & (r_value[i*DIGIT_W +: DIGIT_W] == '0);
            if (r_scan_idx == IDX_W'(i)) begin
                w_scan_digit = r_value[i*DIGIT_W +: DIGIT_W];
                w_scan_blank = (BLANK_LZ != 0) && (i != 0) && w_upper_zero;
            end
        end
    end

    seg_hex_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_decode (
        .i_digit (w_scan_digit),
        .i_blank (w_scan_blank),
        .o_seg   (w_seg_decoded)
    );

    assign w_dig_onehot = NUM_DIGITS'(1) << r_scan_idx;

    // Register segments and digit select together so they always describe the same digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_IDLE;
            r_dig <= DIG_IDLE;
        end else begin
            r_seg <= (ACTIVE_LOW != 0) ? ~w_seg_decoded : w_seg_decoded;
            r_dig <= (ACTIVE_LOW != 0) ? ~w_dig_onehot  : w_dig_onehot;
        end
    end

    assign seg       = r_seg;
    assign dig       = r_dig;
    assign value     = r_value;
    assign wrap      = r_wrap;
    assign heartbeat = r_heartbeat;

endmodule

// File: tb/tb_seg_counter_mux.sv
// Bench for seg_counter_mux: a decimal instance and a hex instance with
// leading-zero blanking share stimulus; an integer-arithmetic reference model
// queues expected outputs every clock and a checker compares them.
module tb_seg_counter_mux;

    localparam int TICK_DIV = 4;
    localparam int MUX_DIV  = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       clr;

    logic [6:0] seg_d, seg_h;
    logic [1:0] dig_d, dig_h;
    logic [7:0] value_d, value_h;
    logic       wrap_d, wrap_h;
    logic       hb_d, hb_h;

    int n_checks = 0;
    int n_pass   = 0;

    seg_counter_mux #(
        .TICK_DIV   (TICK_DIV),
        .NUM_DIGITS (2),
        .MUX_DIV    (MUX_DIV),
        .HEX_MODE   (0),
        .ACTIVE_LOW (1),
        .BLANK_LZ   (0)
    ) dut_dec (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .clr       (clr),
        .seg       (seg_d),
        .dig       (dig_d),
        .value     (value_d),
        .wrap      (wrap_d),
        .heartbeat (hb_d)
    );

    seg_counter_mux #(
        .TICK_DIV   (TICK_DIV),
        .NUM_DIGITS (2),
        .MUX_DIV    (MUX_DIV),
        .HEX_MODE   (1),
        .ACTIVE_LOW (1),
        .BLANK_LZ   (1)
    ) dut_hex (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .clr       (clr),
        .seg       (seg_h),
        .dig       (dig_h),
        .value     (value_h),
        .wrap      (wrap_h),
        .heartbeat (hb_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyphs, active-high {g..a}, index = digit value.
    logic [6:0] seg_ref [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    typedef struct {
        logic [7:0] val_d;
        logic [7:0] val_h;
        logic [6:0] seg_d;
        logic [6:0] seg_h;
        logic [1:0] dig;
        logic       wrap_d;
        logic       wrap_h;
        logic       hb;
    } exp_t;

    exp_t sb_q [$];

    // Model state: counters held as plain integers.
    int m_presc = 0;
    int m_sc    = 0;
    int m_idx   = 0;
    int m_vd    = 0;
    int m_vh    = 0;
    bit m_hb    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] al(input logic [6:0] p);
        return ~p;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int base, input int idx, input bit blz);
        int         w = base ** idx;
        logic [6:0] p = seg_ref[(v / w) % base];
        if (blz && idx != 0 && (v / w) == 0) p = 7'b0;
        return ~p;
    endfunction

    function automatic logic [1:0] exp_dig(input int idx);
        logic [1:0] oh = 2'b01 << idx;
        return ~oh;
    endfunction

    // Reference model: predict the outputs each edge produces and queue them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc <= 0;
            m_sc    <= 0;
            m_idx   <= 0;
            m_vd    <= 0;
            m_vh    <= 0;
            m_hb    <= 1'b0;
            sb_q.delete();
        end else begin : model_step
            exp_t e;
            bit   tick, wd, wh;
            int   nd, nh;
            tick = en && !clr && (m_presc == TICK_DIV - 1);
            nd = m_vd;
            nh = m_vh;
            wd = 1'b0;
            wh = 1'b0;
            if (clr) begin
                nd = 0;
                nh = 0;
            end else if (tick) begin
                if (up) begin
                    nd = (m_vd + 1) % 100;
                    nh = (m_vh + 1) % 256;
                    wd = (m_vd == 99);
                    wh = (m_vh == 255);
                end else begin
                    nd = (m_vd + 99) % 100;
                    nh = (m_vh + 255) % 256;
                    wd = (m_vd == 0);
                    wh = (m_vh == 0);
                end
            end
            e.val_d  = to_bcd(nd);
            e.val_h  = 8'(nh);
            e.wrap_d = wd;
            e.wrap_h = wh;
            e.hb     = m_hb ^ tick;
            e.seg_d  = exp_seg(m_vd, 10, m_idx, 1'b0);
            e.seg_h  = exp_seg(m_vh, 16, m_idx, 1'b1);
            e.dig    = exp_dig(m_idx);
            sb_q.push_back(e);

            if (clr)      m_presc <= 0;
            else if (en)  m_presc <= (m_presc == TICK_DIV - 1) ? 0 : m_presc + 1;
            m_vd <= nd;
            m_vh <= nh;
            m_hb <= m_hb ^ tick;
            if (m_sc == MUX_DIV - 1) begin
                m_sc  <= 0;
                m_idx <= (m_idx + 1) % 2;
            end else begin
                m_sc  <= m_sc + 1;
            end
        end
    end

    // Scoreboard checker: compare DUT outputs against queued predictions.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_value_d", value_d, e.val_d);
            check("sb_value_h", value_h, e.val_h);
            check("sb_wrap_d",  wrap_d,  e.wrap_d);
            check("sb_wrap_h",  wrap_h,  e.wrap_h);
            check("sb_hb_d",    hb_d,    e.hb);
            check("sb_hb_h",    hb_h,    e.hb);
            check("sb_seg_d",   seg_d,   e.seg_d);
            check("sb_seg_h",   seg_h,   e.seg_h);
            check("sb_dig_d",   dig_d,   e.dig);
            check("sb_dig_h",   dig_h,   e.dig);
        end
    end

    // Wait (bounded) until the model's decimal or hex count reaches target.
    task automatic wait_model(input bit hexsel, input int target, input int budget);
        int n = 0;
        while (((hexsel ? m_vh : m_vd) != target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((hexsel ? m_vh : m_vd) != target) begin
            check("wait_timeout", 32'(hexsel ? m_vh : m_vd), 32'(target));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg_d"},   seg_d,   7'h7F);
        check({tag, "_seg_h"},   seg_h,   7'h7F);
        check({tag, "_dig_d"},   dig_d,   2'b11);
        check({tag, "_dig_h"},   dig_h,   2'b11);
        check({tag, "_value_d"}, value_d, 8'h00);
        check({tag, "_value_h"}, value_h, 8'h00);
        check({tag, "_wrap_d"},  wrap_d,  1'b0);
        check({tag, "_hb_d"},    hb_d,    1'b0);
    endtask

    initial begin
        bit saw;
        rst_n = 1'b0;
        en    = 1'b0;
        up    = 1'b1;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Release and count up: first tick lands four enabled cycles later.
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_first_tick", value_d, 8'h00);
        @(negedge clk);
        check("first_tick", value_d, 8'h01);
        check("first_hb",   hb_d,    1'b1);
        repeat (4) @(negedge clk);
        check("second_tick", value_d, 8'h02);
        check("second_hb",   hb_d,    1'b0);
        repeat (4) @(negedge clk);
        check("third_tick",  value_d, 8'h03);

        // Clear on the tick cycle at 37.
        wait_model(1'b0, 37, 400);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_value_d", value_d, 8'h00);
        check("clr_value_h", value_h, 8'h00);
        check("clr_wrap",    wrap_d,  1'b0);
        repeat (3) @(negedge clk);
        check("clr_no_early_tick", value_d, 8'h00);
        @(negedge clk);
        check("clr_next_tick", value_d, 8'h01);

        // Enable low freezes the count.
        en = 1'b0;
        repeat (20) @(negedge clk);
        check("en_freeze", value_d, 8'h01);

        // Leading-zero blanking on the hex instance at 05.
        en = 1'b1;
        wait_model(1'b0, 5, 100);
        en  = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dig_h == 2'b01) begin
                saw = 1'b1;
                check("blank_digit1", seg_h, 7'h7F);
            end
        end
        check("blank_seen", saw, 1'b1);

        // Borrow: 10 -> 09 decimal, 0A -> 09 hex.
        en = 1'b1;
        wait_model(1'b0, 10, 100);
        up = 1'b0;
        wait_model(1'b0, 9, 20);
        check("borrow_d", value_d, 8'h09);
        check("borrow_h", value_h, 8'h09);

        // Down from 00 wraps to all-max with a single-cycle pulse.
        wait_model(1'b0, 99, 100);
        check("down_wrap_value_d", value_d, 8'h99);
        check("down_wrap_value_h", value_h, 8'hFF);
        check("down_wrap_pulse_d", wrap_d,  1'b1);
        check("down_wrap_pulse_h", wrap_h,  1'b1);
        @(negedge clk);
        check("down_wrap_end_d", wrap_d, 1'b0);
        check("down_wrap_end_h", wrap_h, 1'b0);

        // Hex digit b glyph.
        wait_model(1'b1, 8'hFB, 40);
        en  = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dig_h == 2'b10) begin
                saw = 1'b1;
                check("glyph_b", seg_h, al(7'b1111100));
            end
        end
        check("glyph_b_seen", saw, 1'b1);

        // Up from all-max wraps to 00 on both instances.
        en = 1'b1;
        up = 1'b1;
        wait_model(1'b0, 0, 40);
        check("up_wrap_value_d", value_d, 8'h00);
        check("up_wrap_value_h", value_h, 8'h00);
        check("up_wrap_pulse_d", wrap_d,  1'b1);
        check("up_wrap_pulse_h", wrap_h,  1'b1);

        // Hex carry 0F -> 10.
        wait_model(1'b1, 8'h10, 100);
        check("hex_carry", value_h, 8'h10);

        // Scan at 42: digit 0 shows 2, digit 1 shows 4.
        wait_model(1'b0, 42, 200);
        en = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dig_d == 2'b10)      check("scan_digit0", seg_d, al(seg_ref[2]));
            else if (dig_d == 2'b01) check("scan_digit1", seg_d, al(seg_ref[4]));
            else                     check("scan_onehot", dig_d, 2'b10);
        end

        // Asynchronous reset mid-scan at 58.
        en = 1'b1;
        wait_model(1'b0, 58, 200);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_value", value_d, 8'h00);
        check("restart_dig",   dig_d,   2'b10);
        check("restart_seg",   seg_d,   al(seg_ref[0]));
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
